// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - shared byte-wide memory port between the MEM stage and memory
interface mem_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_gnt;
  logic [7:0]  mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rdata
  );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM stage: byte-serial little-endian loads/stores, zero-latency pass-through otherwise
module mem_stage #(
  parameter int                   OP_TYPE_W = 3,
  parameter int                   OP_W      = 5,
  parameter logic [OP_TYPE_W-1:0] OPT_MEM   = OP_TYPE_W'(2),
  parameter logic [OP_W-1:0]      OP_LB     = OP_W'(0),
  parameter logic [OP_W-1:0]      OP_LH     = OP_W'(1),
  parameter logic [OP_W-1:0]      OP_LW     = OP_W'(2),
  parameter logic [OP_W-1:0]      OP_LBU    = OP_W'(3),
  parameter logic [OP_W-1:0]      OP_LHU    = OP_W'(4),
  parameter logic [OP_W-1:0]      OP_SB     = OP_W'(5),
  parameter logic [OP_W-1:0]      OP_SH     = OP_W'(6),
  parameter logic [OP_W-1:0]      OP_SW     = OP_W'(7)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_TYPE_W-1:0] i_optype,
  input  logic [OP_W-1:0]      i_opname,
  input  logic [4:0]           i_rd_addr,
  input  logic [31:0]          i_rd_data,
  input  logic [31:0]          i_s_data,
  mem_stage_if.master          mem,
  output logic                 o_stall_req,
  output logic [4:0]           o_wb_rd_addr,
  output logic [31:0]          o_wb_rd_data,
  output logic                 o_wb_we
);

  typedef enum logic [1:0] {IDLE, XFER, LAST, DONE} state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_pend;
  logic [31:0] r_asm;

  logic        w_is_load;
  logic        w_is_store;
  logic [1:0]  w_last_idx;
  logic [1:0]  w_cap_idx;
  logic [31:0] w_load_val;

  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_last_idx = 2'd0;
    if (i_optype == OPT_MEM) begin
      case (i_opname)
        OP_LB, OP_LBU: begin w_is_load = 1'b1;  w_last_idx = 2'd0; end
        OP_LH, OP_LHU: begin w_is_load = 1'b1;  w_last_idx = 2'd1; end
        OP_LW:         begin w_is_load = 1'b1;  w_last_idx = 2'd3; end
        OP_SB:         begin w_is_store = 1'b1; w_last_idx = 2'd0; end
        OP_SH:         begin w_is_store = 1'b1; w_last_idx = 2'd1; end
        OP_SW:         begin w_is_store = 1'b1; w_last_idx = 2'd3; end
        default: ;
      endcase
    end
  end

  // idx has already advanced past the byte whose read data arrives now
  assign w_cap_idx = r_idx - 2'd1;

  always_comb begin
    w_load_val = r_asm;
    if (i_opname == OP_LB)       w_load_val = {{24{r_asm[7]}}, r_asm[7:0]};
    else if (i_opname == OP_LBU) w_load_val = {24'd0, r_asm[7:0]};
    else if (i_opname == OP_LH)  w_load_val = {{16{r_asm[15]}}, r_asm[15:0]};
    else if (i_opname == OP_LHU) w_load_val = {16'd0, r_asm[15:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= 2'd0;
      r_pend  <= 1'b0;
      r_asm   <= 32'd0;
    end else begin
      if (r_pend) r_asm[{w_cap_idx, 3'b000} +: 8] <= mem.mem_rdata;
      case (r_state)
        IDLE: begin
          r_pend <= 1'b0;
          if (w_is_load || w_is_store) begin
            r_state <= XFER;
            r_idx   <= 2'd0;
          end
        end
        XFER: begin
          r_pend <= mem.mem_gnt & w_is_load;
          if (mem.mem_gnt) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == w_last_idx) r_state <= w_is_store ? DONE : LAST;
          end
        end
        LAST: begin
          r_pend  <= 1'b0;
          r_state <= DONE;
        end
        default: begin
          r_pend  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from state and the held EX/MEM inputs; rst forces them all low
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = 32'd0;
    mem.mem_wdata = 8'd0;
    o_stall_req   = 1'b0;
    o_wb_rd_addr  = 5'd0;
    o_wb_rd_data  = 32'd0;
    o_wb_we       = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_is_load || w_is_store) begin
            o_stall_req = 1'b1;
          end else begin
            o_wb_rd_addr = i_rd_addr;
            o_wb_rd_data = i_rd_data;
            o_wb_we      = (i_rd_addr != 5'd0);
          end
        end
        XFER: begin
          o_stall_req   = 1'b1;
          mem.mem_req   = 1'b1;
          mem.mem_we    = w_is_store;
          mem.mem_addr  = i_rd_data + {30'd0, r_idx};
          mem.mem_wdata = w_is_store ? i_s_data[{r_idx, 3'b000} +: 8] : 8'd0;
        end
        LAST: o_stall_req = 1'b1;
        default: begin
          o_wb_rd_addr = i_rd_addr;
          if (w_is_load) begin
            o_wb_rd_data = w_load_val;
            o_wb_we      = (i_rd_addr != 5'd0);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage with a byte memory model
module tb_mem_stage;

  localparam int OP_TYPE_W = 3;
  localparam int OP_W      = 5;
  localparam logic [OP_TYPE_W-1:0] T_ALU = 3'd0;
  localparam logic [OP_TYPE_W-1:0] T_MEM = 3'd2;
  localparam logic [OP_W-1:0] LB = 5'd0, LH = 5'd1, LW = 5'd2, LBU = 5'd3, LHU = 5'd4;
  localparam logic [OP_W-1:0] SW = 5'd7, ADD = 5'd8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [OP_TYPE_W-1:0] optype = '0;
  logic [OP_W-1:0]      opname = '0;
  logic [4:0]           rd_addr = '0;
  logic [31:0]          rd_data = '0;
  logic [31:0]          s_data = '0;
  logic                 stall_req;
  logic [4:0]           wb_rd_addr;
  logic [31:0]          wb_rd_data;
  logic                 wb_we;
  logic                 tb_gnt = 1'b1;
  logic [7:0]           ram [0:1023];

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_if m_if ();

  mem_stage #(.OP_TYPE_W(OP_TYPE_W), .OP_W(OP_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_optype    (optype),
    .i_opname    (opname),
    .i_rd_addr   (rd_addr),
    .i_rd_data   (rd_data),
    .i_s_data    (s_data),
    .mem         (m_if),
    .o_stall_req (stall_req),
    .o_wb_rd_addr(wb_rd_addr),
    .o_wb_rd_data(wb_rd_data),
    .o_wb_we     (wb_we)
  );

  always #5 clk = ~clk;

  assign m_if.mem_gnt = tb_gnt & m_if.mem_req;

  // Read data appears the cycle after a granted read; garbage otherwise
  always @(posedge clk) begin
    if (m_if.mem_req && m_if.mem_gnt && m_if.mem_we) ram[m_if.mem_addr[9:0]] <= m_if.mem_wdata;
    if (m_if.mem_req && m_if.mem_gnt && !m_if.mem_we) m_if.mem_rdata <= ram[m_if.mem_addr[9:0]];
    else m_if.mem_rdata <= 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] val);
    optype = T_ALU; opname = ADD; rd_addr = rd; rd_data = val; s_data = 32'd0;
  endtask

  task automatic run_mem(input string tag, input logic [OP_W-1:0] op, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] sdata, input bit is_st,
                         input int hold_byte, input int hold_n,
                         output int stalls, output int grants,
                         output logic [31:0] d_data, output logic d_we, output logic [4:0] d_rd);
    int holds;
    bit done;
    holds = hold_n; done = 1'b0; stalls = 0; grants = 0;
    d_data = 32'hDEAD_DEAD; d_we = 1'bx; d_rd = 5'h1F;
    @(negedge clk);
    optype = T_MEM; opname = op; rd_addr = rd; rd_data = addr; s_data = sdata;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      tb_gnt = !(grants == hold_byte && holds > 0);
      #1;
      if (stall_req) stalls++;
      if (m_if.mem_req) begin
        check({tag, " addr"}, m_if.mem_addr, addr + grants);
        check({tag, " we"}, {31'd0, m_if.mem_we}, {31'd0, is_st});
        check({tag, " wdata"}, {24'd0, m_if.mem_wdata}, is_st ? ((sdata >> (8 * grants)) & 32'hFF) : 32'd0);
        if (tb_gnt) grants++;
        else holds--;
      end else if (!stall_req && stalls > 0) begin
        done = 1'b1;
        d_data = wb_rd_data; d_we = wb_we; d_rd = wb_rd_addr;
      end
      @(negedge clk);
    end
    tb_gnt = 1'b1;
    set_alu(5'd0, 32'd0);
    check({tag, " completed"}, {31'd0, done}, 32'd1);
  endtask

  int st, gr;
  logic [31:0] dd;
  logic dw;
  logic [4:0] dr;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h007] = 8'h80;
    ram[10'h201] = 8'h34; ram[10'h202] = 8'h12;
    ram[10'h300] = 8'h00; ram[10'h301] = 8'h90;
    ram[10'h010] = 8'h01; ram[10'h011] = 8'h02; ram[10'h012] = 8'h03; ram[10'h013] = 8'h04;

    // Reset gates even a live pass-through op
    set_alu(5'd5, 32'h1234);
    repeat (3) @(negedge clk);
    #1;
    check("rst wb_we", {31'd0, wb_we}, 32'd0);
    check("rst wb_rd_data", wb_rd_data, 32'd0);
    check("rst wb_rd_addr", {27'd0, wb_rd_addr}, 32'd0);
    check("rst stall/req", {30'd0, stall_req, m_if.mem_req}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    set_alu(5'd5, 32'h1234);
    #1;
    check("add wb_we", {31'd0, wb_we}, 32'd1);
    check("add wb_rd_addr", {27'd0, wb_rd_addr}, 32'd5);
    check("add wb_rd_data", wb_rd_data, 32'h1234);
    check("add stall/req", {30'd0, stall_req, m_if.mem_req}, 32'd0);

    run_mem("sw", SW, 5'd3, 32'h100, 32'hAABBCCDD, 1'b1, -1, 0, st, gr, dd, dw, dr);
    check("sw stalls", st, 32'd5);
    check("sw grants", gr, 32'd4);
    check("sw wb_we", {31'd0, dw}, 32'd0);
    check("sw wb_rd_data", dd, 32'd0);
    check("sw ram", {ram[10'h103], ram[10'h102], ram[10'h101], ram[10'h100]}, 32'hAABBCCDD);

    run_mem("lb", LB, 5'd6, 32'h7, 32'd0, 1'b0, -1, 0, st, gr, dd, dw, dr);
    check("lb stalls", st, 32'd3);
    check("lb data", dd, 32'hFFFFFF80);
    check("lb wb_we", {31'd0, dw}, 32'd1);
    check("lb wb_rd_addr", {27'd0, dr}, 32'd6);

    run_mem("lbu", LBU, 5'd6, 32'h7, 32'd0, 1'b0, -1, 0, st, gr, dd, dw, dr);
    check("lbu data", dd, 32'h00000080);

    run_mem("lhu", LHU, 5'd9, 32'h201, 32'd0, 1'b0, 1, 2, st, gr, dd, dw, dr);
    check("lhu stalls", st, 32'd6);
    check("lhu data", dd, 32'h00001234);
    check("lhu wb_we", {31'd0, dw}, 32'd1);

    run_mem("lh", LH, 5'd10, 32'h300, 32'd0, 1'b0, -1, 0, st, gr, dd, dw, dr);
    check("lh stalls", st, 32'd4);
    check("lh data", dd, 32'hFFFF9000);

    run_mem("lw x0", LW, 5'd0, 32'h10, 32'd0, 1'b0, -1, 0, st, gr, dd, dw, dr);
    check("lw grants", gr, 32'd4);
    check("lw stalls", st, 32'd6);
    check("lw data", dd, 32'h04030201);
    check("lw wb_we", {31'd0, dw}, 32'd0);

    // Reset in the middle of a store after two granted bytes
    @(negedge clk);
    optype = T_MEM; opname = SW; rd_addr = 5'd4; rd_data = 32'h180; s_data = 32'h11223344;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort req", {31'd0, m_if.mem_req}, 32'd0);
    check("abort stall", {31'd0, stall_req}, 32'd0);
    check("abort addr", m_if.mem_addr, 32'd0);
    check("abort wb", {wb_we, wb_rd_addr, 26'd0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    set_alu(5'd7, 32'hBEEF);
    #1;
    check("post-rst wb_we", {31'd0, wb_we}, 32'd1);
    check("post-rst wb_rd_data", wb_rd_data, 32'hBEEF);
    check("post-rst stall/req", {30'd0, stall_req, m_if.mem_req}, 32'd0);
    check("abort ram", {ram[10'h183], ram[10'h182], ram[10'h181], ram[10'h180]}, 32'h00003344);
    @(negedge clk);
    #1;
    check("post-rst idle req", {31'd0, m_if.mem_req}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM pipeline stage, directly downstream of the EX/MEM pipeline register. It consumes the latched rd address, the ALU result or effective address, the store data and the decoded op.
- Loads and stores run as multi-cycle little-endian transfers over the shared byte-wide memory port. The stage raises stall_req to the stall controller until the transfer completes.
- Non-memory ops pass through to MEM/WB with zero added latency.

Parameters:
- OP_TYPE_W, project opcode-type width, width of optype.
- OP_W, project opcode-name width, width of opname.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- optype  in  OP_TYPE_W  instruction type from EX/MEM.
- opname  in  OP_W  instruction name from EX/MEM; memory codes are LB, LH, LW, LBU, LHU, SB, SH, SW from the shared opcode definitions.
- rd_addr  in  5  destination register.
- rd_data  in  32  ALU result; the effective address for loads and stores.
- s_data  in  32  store data.
- mem_req  out  1  byte-port request.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  32  byte address.
- mem_wdata  out  8  write byte.
- mem_gnt  in  1  port granted this cycle; the byte transfer is accepted at this edge.
- mem_rdata  in  8  read byte, valid the cycle after a granted read.
- stall_req  out  1  hold the upstream pipeline.
- wb_rd_addr  out  5  to MEM/WB.
- wb_rd_data  out  32  to MEM/WB.
- wb_we  out  1  register write enable to MEM/WB.

Behaviour:
- States: IDLE, XFER, LAST, DONE. Internal registers:
  - byte index idx (2 bits)
  - byte count n: 1 for B/BU, 2 for H/HU, 4 for W
  - 32-bit assembly register
  - pend flag, set when the previous cycle's read was granted
- Reset, whenever rst=1 at an edge:
  - state IDLE, idx=0, pend=0, assembly=0.
  - During rst=1 every output is 0: mem_req, mem_we, mem_addr, mem_wdata, stall_req, wb_rd_addr, wb_rd_data, wb_we.
- Reset mid-transfer aborts the transfer. Bytes already written are not rolled back, and no wb_we pulse is produced.
- IDLE with a non-memory op:
  - combinational pass-through: wb_rd_addr=rd_addr, wb_rd_data=rd_data, wb_we=(rd_addr!=0).
  - stall_req=0, mem_req=0.
- IDLE with a memory op:
  - stall_req=1 in the same cycle, wb_we=0, mem_req=0.
  - Next state XFER with idx=0.
- XFER:
  - Drives mem_req=1 and mem_addr=rd_data+idx (32-bit wrap).
  - Stores: mem_we=1, mem_wdata=s_data[8*idx+7:8*idx].
  - Loads: mem_we=0, mem_wdata=0.
  - On mem_gnt=1: idx increments. If mem_gnt=0: idx holds and mem_addr/mem_wdata stay stable.
  - After the granted byte idx=n-1: stores go to DONE, loads go to LAST.
  - stall_req=1 throughout.
- Load data capture:
  - While pend=1, mem_rdata is written to assembly byte (idx-1), i.e. the byte granted in the previous cycle.
  - This capture happens in XFER and in LAST.
- LAST: mem_req=0; captures the final byte; next state DONE; stall_req=1.
- DONE, exactly one cycle:
  - stall_req=0, mem_req=0, wb_rd_addr=rd_addr.
  - Stores: wb_we=0, wb_rd_data=0.
  - Loads: wb_we=(rd_addr!=0).
  - Load extension of wb_rd_data:
    - LB sign-extends bit 7; LBU zero-extends.
    - LH sign-extends bit 15; LHU zero-extends.
    - LW uses the full word.
  - Next state IDLE unconditionally. The op presented in the following cycle is treated as new, because EX/MEM advanced on the DONE edge.
- Latency with mem_gnt held at 1:
  - store = n+2 cycles of stall_req-inclusive occupancy, i.e. n+1 cycles of stall_req=1;
  - load = n+3 cycles.
- Each cycle of mem_gnt=0 in XFER adds one cycle.
- Addresses are not alignment-checked. Byte-serial access makes misaligned transfers legal.
- EX/MEM inputs are held stable while stall_req=1. The stage relies on this and latches nothing from them except state, idx and assembly.

Test Plan:
- ADD, rd=x5, rd_data=0x1234, IDLE -> same cycle wb_we=1, wb_rd_addr=5, wb_rd_data=0x1234, stall_req=0, mem_req=0.
- SW, addr=0x100, s_data=0xAABBCCDD, mem_gnt=1 -> writes 0xDD@0x100, 0xCC@0x101, 0xBB@0x102, 0xAA@0x103 on consecutive cycles; stall_req=1 for 5 cycles; DONE with wb_we=0.
- LB, addr=0x7, memory byte 0x80 -> DONE wb_rd_data=0xFFFFFF80, wb_we=1. Same test with LBU -> 0x00000080.
- LHU, addr=0x201, bytes 0x34,0x12, mem_gnt low for 2 cycles on byte 1:
  - mem_addr holds 0x202 during the stall;
  - result 0x00001234;
  - total stall 6 cycles.
- LW, rd=x0 -> full 4-byte read still performed; DONE has wb_we=0.
- rst=1 during XFER of SW after 2 granted bytes -> next cycle all outputs 0, state IDLE, no further mem_req; after release a non-memory op passes through immediately.
